instr_fetch_queue: RTL and testbench

Fetch stage between the program counter and instruction decode of the MIPS core. Owns the fetch PC, issues word reads to a variable-latency instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes entries over a valid/ready interface. The branch/jump unit redirects fetch, which flushes all in-flight and buffered work.

---
 rtl/instr_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, keeps at most one word read in flight to instruction
// memory, and buffers returned instructions with their PCs in a FIFO for decode.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [31:0]            mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [31:0]            mem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_data,
    output logic [31:0]            inst_pc,
    output logic [31:0]            inst_pc4,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     data_mem_q [DEPTH];
    logic [31:0]     pc_mem_q   [DEPTH];

    logic            fifo_full;
    logic            req_fire;
    logic            push;
    logic            pop;

    assign fifo_full = (count_q == CW'(DEPTH));
    assign req_fire  = mem_req_valid && mem_req_ready;
    assign pop       = inst_valid && inst_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_fire)      state_d = ST_WAIT;
            ST_WAIT: begin
                // A response always closes the transaction; only a pending one is dropped.
                if (mem_rsp_valid)       state_d = ST_IDLE;
                else if (redirect_valid) state_d = ST_DROP;
            end
            ST_DROP: if (mem_rsp_valid) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_valid = rst_n && (state_q == ST_IDLE) && !fifo_full && !redirect_valid;
        push          = (state_q == ST_WAIT) && mem_rsp_valid && !redirect_valid;
    end

    // ------------------------------------------------------------------
    // Fetch PC and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & WORD_MASK;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC & WORD_MASK;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; count_q qualifies every
    // read, and the outputs are forced to zero whenever nothing valid is held.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= mem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        inst_valid = rst_n && (count_q != '0);
        inst_data  = '0;
        inst_pc    = '0;
        inst_pc4   = '0;
        if (inst_valid) begin
            inst_data = data_mem_q[rd_ptr_q];
            inst_pc   = pc_mem_q[rd_ptr_q];
            inst_pc4  = pc_mem_q[rd_ptr_q] + 32'd4;
        end
    end

    assign mem_req_addr = fetch_pc_q;
    assign occupancy    = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: per-cycle vectors of inputs and hand-computed
// outputs, applied just after the rising edge and checked on the falling edge.
module tb_instr_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        redir;
        logic [31:0] redir_pc;
        logic        inst_ready;
        logic        exp_req_valid;
        logic [31:0] exp_addr;
        logic        exp_inst_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
        logic [31:0] exp_pc4;
        int          exp_occ;
    } vec_t;

    // Memory returns addr ^ KEY; an empty FIFO must present zeros on inst_*.
    function automatic vec_t mk(input int rst, input int rdy, input int rsp,
                                input logic [31:0] rsp_addr, input int redir,
                                input logic [31:0] rpc, input int irdy, input int erv,
                                input logic [31:0] eaddr, input int eiv,
                                input logic [31:0] epc, input int eocc);
        vec_t m;
        m.rst_n          = (rst != 0);
        m.req_ready      = (rdy != 0);
        m.rsp_valid      = (rsp != 0);
        m.rsp_data       = (rsp != 0) ? (rsp_addr ^ KEY) : 32'h0;
        m.redir          = (redir != 0);
        m.redir_pc       = rpc;
        m.inst_ready     = (irdy != 0);
        m.exp_req_valid  = (erv != 0);
        m.exp_addr       = eaddr;
        m.exp_inst_valid = (eiv != 0);
        m.exp_pc         = (eiv != 0) ? epc : 32'h0;
        m.exp_data       = (eiv != 0) ? (epc ^ KEY) : 32'h0;
        m.exp_pc4        = (eiv != 0) ? (epc + 32'd4) : 32'h0;
        m.exp_occ        = eocc;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; drives the cycle's inputs, checks mid-cycle.
    task automatic run(input vec_t v, input string tag);
        rst_n          = v.rst_n;
        mem_req_ready  = v.req_ready;
        mem_rsp_valid  = v.rsp_valid;
        mem_rsp_data   = v.rsp_data;
        redirect_valid = v.redir;
        redirect_pc    = v.redir_pc;
        inst_ready     = v.inst_ready;
        @(negedge clk);
        check({tag, ".req_valid"},  32'(mem_req_valid), 32'(v.exp_req_valid));
        check({tag, ".req_addr"},   mem_req_addr,       v.exp_addr);
        check({tag, ".inst_valid"}, 32'(inst_valid),    32'(v.exp_inst_valid));
        check({tag, ".inst_pc"},    inst_pc,            v.exp_pc);
        check({tag, ".inst_data"},  inst_data,          v.exp_data);
        check({tag, ".inst_pc4"},   inst_pc4,           v.exp_pc4);
        check({tag, ".occupancy"},  32'(occupancy),     32'(v.exp_occ));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string grp, input int rst, input int rdy, input int rsp,
                       input logic [31:0] rsp_addr, input int redir, input logic [31:0] rpc,
                       input int irdy, input int erv, input logic [31:0] eaddr,
                       input int eiv, input logic [31:0] epc, input int eocc);
        run(mk(rst, rdy, rsp, rsp_addr, redir, rpc, irdy, erv, eaddr, eiv, epc, eocc),
            $sformatf("%s.%0d", grp, cyc_n));
        cyc_n++;
    endtask

    initial begin
        vec_t tbl[$];

        rst_n          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Streaming fetch, 1-cycle memory: one instruction every two cycles.
        //           rst rdy rsp addr    rd rpc ir  erv eaddr    eiv epc      occ
        tbl.push_back(mk(0, 1, 0, 32'h0,  0, 0, 1,  0, 32'h0,   0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  1, 32'h0,   0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 1, 32'h0,  0, 0, 1,  0, 32'h4,   0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  1, 32'h4,   1, 32'h0,  1));
        tbl.push_back(mk(1, 1, 1, 32'h4,  0, 0, 1,  0, 32'h8,   0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  1, 32'h8,   1, 32'h4,  1));
        tbl.push_back(mk(1, 1, 1, 32'h8,  0, 0, 1,  0, 32'hC,   0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  1, 32'hC,   1, 32'h8,  1));
        tbl.push_back(mk(1, 1, 1, 32'hC,  0, 0, 1,  0, 32'h10,  0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  1, 32'h10,  1, 32'hC,  1));
        // Reset, then fill to DEPTH with decode stalled, then drain in order.
        tbl.push_back(mk(0, 1, 0, 32'h0,  0, 0, 1,  0, 32'h14,  0, 32'h0,  0));
        tbl.push_back(mk(0, 1, 0, 32'h0,  0, 0, 0,  0, 32'h0,   0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 0,  1, 32'h0,   0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 1, 32'h0,  0, 0, 0,  0, 32'h4,   0, 32'h0,  0));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 0,  1, 32'h4,   1, 32'h0,  1));
        tbl.push_back(mk(1, 1, 1, 32'h4,  0, 0, 0,  0, 32'h8,   1, 32'h0,  1));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 0,  1, 32'h8,   1, 32'h0,  2));
        tbl.push_back(mk(1, 1, 1, 32'h8,  0, 0, 0,  0, 32'hC,   1, 32'h0,  2));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 0,  1, 32'hC,   1, 32'h0,  3));
        tbl.push_back(mk(1, 1, 1, 32'hC,  0, 0, 0,  0, 32'h10,  1, 32'h0,  3));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 0,  0, 32'h10,  1, 32'h0,  4));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 0,  0, 32'h10,  1, 32'h0,  4));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  0, 32'h10,  1, 32'h0,  4));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  1, 32'h10,  1, 32'h4,  3));
        tbl.push_back(mk(1, 1, 1, 32'h10, 0, 0, 1,  0, 32'h14,  1, 32'h8,  2));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  1, 32'h14,  1, 32'hC,  2));
        tbl.push_back(mk(1, 1, 1, 32'h14, 0, 0, 1,  0, 32'h18,  1, 32'h10, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,  0, 0, 1,  1, 32'h18,  1, 32'h14, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Redirect while a slow (5-cycle) read is pending: its data must be dropped.
        cyc("drop", 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 32'h1C, 0, 32'h0,  0);
        cyc("drop", 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0);
        cyc("drop", 1, 1, 0, 32'h0,  1, 32'h10, 1, 0, 32'h0,  0, 32'h0,  0);
        cyc("drop", 1, 1, 0, 32'h0,  0, 32'h0,  1, 1, 32'h10, 0, 32'h0,  0);
        cyc("drop", 1, 1, 0, 32'h0,  0, 32'h0,  1, 0, 32'h14, 0, 32'h0,  0);
        cyc("drop", 1, 1, 0, 32'h0,  1, 32'h48, 1, 0, 32'h14, 0, 32'h0,  0);
        cyc("drop", 1, 1, 0, 32'h0,  0, 32'h0,  1, 0, 32'h48, 0, 32'h0,  0);
        cyc("drop", 1, 1, 0, 32'h0,  0, 32'h0,  1, 0, 32'h48, 0, 32'h0,  0);
        cyc("drop", 1, 1, 1, 32'h10, 0, 32'h0,  1, 0, 32'h48, 0, 32'h0,  0);
        cyc("drop", 1, 1, 0, 32'h0,  0, 32'h0,  1, 1, 32'h48, 0, 32'h0,  0);
        cyc("drop", 1, 1, 1, 32'h48, 0, 32'h0,  1, 0, 32'h4C, 0, 32'h0,  0);
        cyc("drop", 1, 1, 0, 32'h0,  0, 32'h0,  1, 1, 32'h4C, 1, 32'h48, 1);

        // Redirect coinciding with a response and a pop, two entries buffered.
        cyc("flush", 0, 1, 0, 32'h0,  0, 32'h0,   0, 0, 32'h50,  0, 32'h0,   0);
        cyc("flush", 0, 1, 0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0);
        cyc("flush", 1, 1, 0, 32'h0,  0, 32'h0,   0, 1, 32'h0,   0, 32'h0,   0);
        cyc("flush", 1, 1, 1, 32'h0,  0, 32'h0,   0, 0, 32'h4,   0, 32'h0,   0);
        cyc("flush", 1, 1, 0, 32'h0,  0, 32'h0,   0, 1, 32'h4,   1, 32'h0,   1);
        cyc("flush", 1, 1, 1, 32'h4,  0, 32'h0,   0, 0, 32'h8,   1, 32'h0,   1);
        cyc("flush", 1, 1, 0, 32'h0,  0, 32'h0,   0, 1, 32'h8,   1, 32'h0,   2);
        cyc("flush", 1, 1, 1, 32'h8,  1, 32'h200, 1, 0, 32'hC,   1, 32'h0,   2);
        cyc("flush", 1, 1, 0, 32'h0,  0, 32'h0,   1, 1, 32'h200, 0, 32'h0,   0);
        cyc("flush", 1, 1, 1, 32'h200, 0, 32'h0,  1, 0, 32'h204, 0, 32'h0,   0);
        cyc("flush", 1, 1, 0, 32'h0,  0, 32'h0,   1, 1, 32'h204, 1, 32'h200, 1);

        // Misaligned redirect target and fetch PC wrap past the top of memory.
        cyc("wrap", 0, 1, 0, 32'h0,         0, 32'h0,         1, 0, 32'h208,       0, 32'h0,         0);
        cyc("wrap", 0, 1, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0);
        cyc("wrap", 1, 1, 0, 32'h0,         1, 32'hFFFF_FFFE, 1, 0, 32'h0,         0, 32'h0,         0);
        cyc("wrap", 1, 1, 0, 32'h0,         0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,         0);
        cyc("wrap", 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0);
        cyc("wrap", 1, 1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFF_FFFC, 1);
        cyc("wrap", 1, 1, 1, 32'h0,         0, 32'h0,         1, 0, 32'h4,         0, 32'h0,         0);
        cyc("wrap", 1, 1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h4,         1, 32'h0,         1);

        // One-cycle reset while a read is pending with three entries buffered.
        cyc("rst", 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h8,  0, 32'h0, 0);
        cyc("rst", 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,  0, 32'h0, 0);
        cyc("rst", 1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0,  0, 32'h0, 0);
        cyc("rst", 1, 1, 1, 32'h0, 0, 32'h0, 0, 0, 32'h4,  0, 32'h0, 0);
        cyc("rst", 1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h4,  1, 32'h0, 1);
        cyc("rst", 1, 1, 1, 32'h4, 0, 32'h0, 0, 0, 32'h8,  1, 32'h0, 1);
        cyc("rst", 1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h8,  1, 32'h0, 2);
        cyc("rst", 1, 1, 1, 32'h8, 0, 32'h0, 0, 0, 32'hC,  1, 32'h0, 2);
        cyc("rst", 1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'hC,  1, 32'h0, 3);
        cyc("rst", 0, 1, 0, 32'h0, 0, 32'h0, 1, 0, 32'h10, 0, 32'h0, 3);
        cyc("rst", 1, 1, 0, 32'h0, 0, 32'h0, 1, 1, 32'h0,  0, 32'h0, 0);
        cyc("rst", 1, 1, 1, 32'h0, 0, 32'h0, 1, 0, 32'h4,  0, 32'h0, 0);
        cyc("rst", 1, 1, 0, 32'h0, 0, 32'h0, 1, 1, 32'h4,  1, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
